// File: rtl/serial_add_defs.sv
// rtl/serial_add_defs.sv - shared state encoding and default width for the serial adder
package serial_add_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational 1-bit full adder from two cascaded half-add stages
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;
  logic w_g1;
  logic w_g2;

  assign w_p  = x ^ y;
  assign w_g1 = x & y;
  assign s    = w_p ^ ci;
  assign w_g2 = w_p & ci;
  assign co   = w_g1 | w_g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer, LSB first over WIDTH cycles
module serial_adder_ctrl
  import serial_add_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  // Only the upper WIDTH-1 result bits are kept; the newest bit joins them on the last step.
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_acc_nxt;

  serial_fa_cell u_fa (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );

  assign w_acc_nxt = {w_s, r_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_load) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_c    <= cin;
      r_cnt  <= '0;
      r_acc  <= '0;
    end else if (w_step) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_c    <= w_co;
      r_acc  <= w_acc_nxt[WIDTH-1:1];
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_co;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2
module tb_serial_adder_ctrl;

  typedef struct {
    int acc;
    int exp;
  } op_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cin;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  logic       busy_o [2];
  logic       done_o [2];
  logic [8:0] res_o  [2];

  int  cyc;
  int  n_checks;
  int  n_fail;
  int  next_free [2];
  int  last_res  [2];
  logic prev_done [2];
  op_t q [2][$];

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[1:0]), .b(b_in[1:0]), .cin(cin),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  assign busy_o[0] = busy8;
  assign busy_o[1] = busy2;
  assign done_o[0] = done8;
  assign done_o[1] = done2;
  assign res_o[0]  = {cout8, sum8};
  assign res_o[1]  = {6'd0, cout2, sum2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic int wid(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (W=%0d) at cycle %0d: got %0h, expected %0h", nm, wid(d), cyc, act, exp);
    end
  endtask

  // Reference model: a controller that is free again WIDTH+1 edges after an accepted start.
  task automatic drive(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic c);
    op_t op;
    int  msk;
    @(negedge clk);
    start = s;
    a_in  = av;
    b_in  = bv;
    cin   = c;
    if (s && rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (cyc + 1 >= next_free[d]) begin
          msk    = (1 << wid(d)) - 1;
          op.acc = cyc + 1;
          op.exp = (int'(av) & msk) + (int'(bv) & msk) + int'(c);
          q[d].push_back(op);
          next_free[d] = cyc + 1 + wid(d) + 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, busy_o[d], 0);
      chk("rst_done", d, done_o[d], 0);
      chk("rst_result", d, res_o[d], 0);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      next_free[d] = 0;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          last_res[d]  = 0;
          prev_done[d] = 1'b0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          eb = 1'b0;
          foreach (q[d][i]) begin
            if (cyc >= q[d][i].acc && cyc < q[d][i].acc + wid(d)) eb = 1'b1;
          end
          chk("busy", d, busy_o[d], eb);
          if (done_o[d]) begin
            op_t op;
            chk("done_width", d, prev_done[d], 0);
            if (q[d].size() == 0) begin
              chk("unexpected_done", d, done_o[d], 0);
            end else begin
              op = q[d].pop_front();
              chk("done_cycle", d, cyc, op.acc + wid(d));
              chk("result", d, res_o[d], op.exp);
              last_res[d] = op.exp;
            end
          end else begin
            chk("result_hold", d, res_o[d], last_res[d]);
            if (q[d].size() > 0 && cyc > q[d][0].acc + wid(d)) begin
              chk("missing_done", d, done_o[d], 1);
              void'(q[d].pop_front());
            end
          end
          prev_done[d] = done_o[d];
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 2; d++) begin
      next_free[d] = 0;
      last_res[d]  = 0;
      prev_done[d] = 1'b0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    cin   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    #1 rst_n = 1'b1;

    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    idle(11);
    drive(1'b1, 8'h5A, 8'hA5, 1'b1);
    idle(11);
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    idle(11);

    drive(1'b1, 8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    idle(11);

    for (int i = 0; i < 40; i++) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    idle(11);

    drive(1'b1, 8'hC3, 8'h3C, 1'b1);
    idle(3);
    mid_reset();
    idle(12);
    drive(1'b1, 8'h7F, 8'h01, 1'b1);
    idle(11);

    for (int i = 0; i < 12000; i++)
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    idle(12);

    for (int d = 0; d < 2; d++) chk("drained", d, q[d].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
